gray_neighbour_packer: RTL and testbench

- Upstream feeder for the optic-flow gradient custom instruction.
- Consumes a raster stream of 8-bit grayscale pixels and keeps two rolling line buffers.
- For every centre pixel it emits one packed 32-bit neighbour word {down, up, right, left}, byte-aligned so the CPU/DMA can hand it directly to the gradient instruction as operand A.
- Sits between the camera grayscale converter and the DMA/CPU-side FIFO.

---
 rtl/gray_neighbour_packer_pkg.sv | 16 +
 rtl/gray_line_ram.sv | 32 +++
 rtl/gray_neighbour_packer.sv | 120 ++++++++++++
 tb/tb_gray_neighbour_packer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_neighbour_packer_pkg.sv
// Shared optic-flow constants: neighbour-word byte lanes, default row length,
// and the mod-3 row-pointer step used to rotate the line buffers.
package gray_neighbour_packer_pkg;

  localparam int LEFT_LSB  = 0;
  localparam int RIGHT_LSB = 8;
  localparam int UP_LSB    = 16;
  localparam int DOWN_LSB  = 24;

  localparam int DEFAULT_LINE_WIDTH = 640;

  function automatic logic [1:0] row_ptr_inc(input logic [1:0] ptr);
    return (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
  endfunction

endpackage

// File: rtl/gray_line_ram.sv
// One image row of 8-bit pixels: single synchronous write port, three
// asynchronous read ports (left / centre / right neighbour taps).
module gray_line_ram #(
  parameter int DEPTH     = 640,
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [7:0]           wdata,
  input  logic [ADDR_BITS-1:0] raddr_a,
  input  logic [ADDR_BITS-1:0] raddr_b,
  input  logic [ADDR_BITS-1:0] raddr_c,
  output logic [7:0]           rdata_a,
  output logic [7:0]           rdata_b,
  output logic [7:0]           rdata_c
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0] mem [DEPTH];

  // Contents are deliberately not reset; every location is written before use.
  always_ff @(posedge clk) begin
    if (we) mem[waddr[AW-1:0]] <= wdata;
  end

  assign rdata_a = mem[raddr_a[AW-1:0]];
  assign rdata_b = mem[raddr_b[AW-1:0]];
  assign rdata_c = mem[raddr_c[AW-1:0]];

endmodule

// File: rtl/gray_neighbour_packer.sv
// Raster pixel stream in, one {down,up,right,left} word per centre pixel out,
// one cycle after the pixel below the centre is accepted; single output register.
module gray_neighbour_packer
  import gray_neighbour_packer_pkg::*;
#(
  parameter int LINE_WIDTH = DEFAULT_LINE_WIDTH,
  parameter int X_BITS     = 10,
  parameter int Y_BITS     = 9
) (
  input  logic              clock,
  input  logic              nReset,
  input  logic              frameStart,
  input  logic              pixelValid,
  input  logic [7:0]        pixelData,
  output logic              pixelReady,
  output logic              neighValid,
  input  logic              neighReady,
  output logic [31:0]       neighWord,
  output logic [X_BITS-1:0] neighX,
  output logic [Y_BITS-1:0] neighY
);

  localparam logic [X_BITS-1:0] X_LAST = X_BITS'(LINE_WIDTH - 1);

  logic [X_BITS-1:0] x_cnt;
  logic [Y_BITS-1:0] y_cnt;
  logic [1:0]        row_ptr;

  logic              accept;
  logic [X_BITS-1:0] eff_x;
  logic [Y_BITS-1:0] eff_y;
  logic [1:0]        eff_ptr;
  logic [1:0]        r1_sel;
  logic [1:0]        r2_sel;
  logic [X_BITS-1:0] addr_l;
  logic [X_BITS-1:0] addr_r;
  logic [Y_BITS-1:0] y_inc;
  logic [31:0]       new_word;

  logic [2:0][7:0]   rd_l;
  logic [2:0][7:0]   rd_c;
  logic [2:0][7:0]   rd_r;

  assign pixelReady = ~neighValid | neighReady;
  assign accept     = pixelValid & pixelReady;

  // frameStart overrides the counters combinationally so the qualifying pixel
  // itself lands at (0,0) in RAM 0.
  assign eff_x   = frameStart ? '0   : x_cnt;
  assign eff_y   = frameStart ? '0   : y_cnt;
  assign eff_ptr = frameStart ? 2'd0 : row_ptr;

  // Row y-1 lives two steps ahead of the write pointer, row y-2 one step ahead.
  assign r2_sel = row_ptr_inc(eff_ptr);
  assign r1_sel = row_ptr_inc(r2_sel);

  assign addr_l = (eff_x == '0)     ? '0     : eff_x - X_BITS'(1);
  assign addr_r = (eff_x == X_LAST) ? X_LAST : eff_x + X_BITS'(1);
  assign y_inc  = (&y_cnt)          ? y_cnt  : eff_y + Y_BITS'(1);

  for (genvar g = 0; g < 3; g++) begin : g_row
    gray_line_ram #(
      .DEPTH    (LINE_WIDTH),
      .ADDR_BITS(X_BITS)
    ) u_ram (
      .clk    (clock),
      .we     (accept && (eff_ptr == 2'(g))),
      .waddr  (eff_x),
      .wdata  (pixelData),
      .raddr_a(addr_l),
      .raddr_b(eff_x),
      .raddr_c(addr_r),
      .rdata_a(rd_l[g]),
      .rdata_b(rd_c[g]),
      .rdata_c(rd_r[g])
    );
  end

  always_comb begin
    new_word = '0;
    new_word[LEFT_LSB  +: 8] = rd_l[r1_sel];
    new_word[RIGHT_LSB +: 8] = rd_r[r1_sel];
    new_word[UP_LSB    +: 8] = (eff_y >= Y_BITS'(2)) ? rd_c[r2_sel] : rd_c[r1_sel];
    new_word[DOWN_LSB  +: 8] = pixelData;
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      x_cnt      <= '0;
      y_cnt      <= '0;
      row_ptr    <= 2'd0;
      neighValid <= 1'b0;
      neighWord  <= '0;
      neighX     <= '0;
      neighY     <= '0;
    end else begin
      if (accept) begin
        if (eff_x == X_LAST) begin
          x_cnt   <= '0;
          y_cnt   <= y_inc;
          row_ptr <= row_ptr_inc(eff_ptr);
        end else begin
          x_cnt   <= eff_x + X_BITS'(1);
          y_cnt   <= eff_y;
          row_ptr <= eff_ptr;
        end
      end

      if (accept && (eff_y != '0)) begin
        neighValid <= 1'b1;
        neighWord  <= new_word;
        neighX     <= eff_x;
        neighY     <= eff_y - Y_BITS'(1);
      end else if (neighReady) begin
        neighValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gray_neighbour_packer.sv
// Directed checks on a 4-pixel-wide instance plus a model-checked random run
// on a 640-pixel-wide instance.
module tb_gray_neighbour_packer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic nReset;

  logic        a_fs, a_valid, a_ready, a_nvalid, a_nready;
  logic [7:0]  a_data;
  logic [31:0] a_word;
  logic [9:0]  a_x;
  logic [8:0]  a_y;

  logic        b_fs, b_valid, b_ready, b_nvalid, b_nready;
  logic [7:0]  b_data;
  logic [31:0] b_word;
  logic [9:0]  b_x;
  logic [8:0]  b_y;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp4 [8];
  logic [31:0] a_q [$];
  logic [50:0] b_q [$];
  logic [50:0] b_exp [$];
  bit          drv_done;

  gray_neighbour_packer #(.LINE_WIDTH(4), .X_BITS(10), .Y_BITS(9)) dut4 (
    .clock(clock), .nReset(nReset), .frameStart(a_fs), .pixelValid(a_valid),
    .pixelData(a_data), .pixelReady(a_ready), .neighValid(a_nvalid),
    .neighReady(a_nready), .neighWord(a_word), .neighX(a_x), .neighY(a_y)
  );

  gray_neighbour_packer #(.LINE_WIDTH(640), .X_BITS(10), .Y_BITS(9)) dut640 (
    .clock(clock), .nReset(nReset), .frameStart(b_fs), .pixelValid(b_valid),
    .pixelData(b_data), .pixelReady(b_ready), .neighValid(b_nvalid),
    .neighReady(b_nready), .neighWord(b_word), .neighX(b_x), .neighY(b_y)
  );

  always @(negedge clock) begin
    if (a_nvalid && a_nready) a_q.push_back(a_word);
    if (b_nvalid && b_nready) b_q.push_back({b_y, b_x, b_word});
  end

  task automatic send4(input logic fs, input logic [7:0] d);
    int w;
    a_valid = 1'b1; a_fs = fs; a_data = d; w = 0;
    @(negedge clock);
    while (!a_ready && w < 100) begin
      @(negedge clock);
      w++;
    end
    if (!a_ready) begin
      total++; bad++;
      $display("FAIL send4_timeout: pixelReady=%b required 1", a_ready);
    end
    @(posedge clock); #1;
    a_valid = 1'b0; a_fs = 1'b0;
  endtask

  task automatic run_frame4(input bit stall, input string tag);
    int px, py;
    logic [7:0] d;
    for (int i = 0; i < 12; i++) begin
      px = i % 4; py = i / 4; d = 8'(16 * py + px);
      if (stall && i == 5) begin
        a_nready = 1'b0; a_valid = 1'b1; a_fs = 1'b0; a_data = d;
        for (int c = 0; c < 5; c++) begin
          @(posedge clock); #1;
          total++;
          if (a_ready !== 1'b0) begin
            bad++; $display("FAIL %s stall_ready: got %b want 0", tag, a_ready);
          end
          total++;
          if (a_nvalid !== 1'b1 || a_word !== exp4[0]) begin
            bad++; $display("FAIL %s stall_hold: got v=%b %h want v=1 %h", tag, a_nvalid, a_word, exp4[0]);
          end
        end
        a_nready = 1'b1;
        @(negedge clock);
        total++;
        if (a_ready !== 1'b1) begin
          bad++; $display("FAIL %s release_ready: got %b want 1", tag, a_ready);
        end
        @(posedge clock); #1;
        a_valid = 1'b0;
      end else begin
        send4(i == 0, d);
      end
      if (py == 0) begin
        total++;
        if (a_nvalid !== 1'b0) begin
          bad++; $display("FAIL %s row0_valid px=%0d: got %b want 0", tag, px, a_nvalid);
        end
      end else begin
        total++;
        if (a_nvalid !== 1'b1 || a_word !== exp4[i-4]) begin
          bad++; $display("FAIL %s word i=%0d: got v=%b %h want v=1 %h", tag, i, a_nvalid, a_word, exp4[i-4]);
        end
        total++;
        if (a_x !== 10'(px) || a_y !== 9'(py - 1)) begin
          bad++; $display("FAIL %s xy i=%0d: got %0d,%0d want %0d,%0d", tag, i, a_x, a_y, px, py - 1);
        end
      end
    end
    @(posedge clock); #1;
    total++;
    if (a_nvalid !== 1'b0) begin
      bad++; $display("FAIL %s drain_valid: got %b want 0", tag, a_nvalid);
    end
  endtask

  task automatic test_reset();
    nReset = 1'b0;
    a_fs = 0; a_valid = 0; a_data = 0; a_nready = 1;
    b_fs = 0; b_valid = 0; b_data = 0; b_nready = 1;
    #12;
    total++;
    if (a_nvalid !== 1'b0 || a_word !== 32'h0 || a_x !== 10'd0 || a_y !== 9'd0) begin
      bad++; $display("FAIL reset_outputs: got v=%b w=%h x=%0d y=%0d want all 0", a_nvalid, a_word, a_x, a_y);
    end
    total++;
    if (a_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ready: got %b want 1", a_ready);
    end
    #5 nReset = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_stream();
    run_frame4(1'b0, "stream");
  endtask

  task automatic test_backpressure();
    a_q.delete();
    run_frame4(1'b1, "bp");
    total++;
    if (a_q.size() !== 8) begin
      bad++; $display("FAIL bp_count: got %0d want 8", a_q.size());
    end
    for (int i = 0; i < 8 && i < a_q.size(); i++) begin
      total++;
      if (a_q[i] !== exp4[i]) begin
        bad++; $display("FAIL bp_seq i=%0d: got %h want %h", i, a_q[i], exp4[i]);
      end
    end
  endtask

  task automatic test_midframe();
    for (int i = 0; i < 6; i++) send4(i == 0, 8'(16 * (i / 4) + (i % 4)));
    send4(1'b1, 8'h50);
    total++;
    if (a_nvalid !== 1'b0) begin
      bad++; $display("FAIL mid_restart_valid: got %b want 0", a_nvalid);
    end
    send4(1'b0, 8'h51);
    send4(1'b0, 8'h52);
    send4(1'b0, 8'h53);
    send4(1'b0, 8'h60);
    total++;
    if (a_nvalid !== 1'b1 || a_word !== 32'h60_50_51_50) begin
      bad++; $display("FAIL mid_first_word: got v=%b %h want v=1 60505150", a_nvalid, a_word);
    end
    total++;
    if (a_x !== 10'd0 || a_y !== 9'd0) begin
      bad++; $display("FAIL mid_first_xy: got %0d,%0d want 0,0", a_x, a_y);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) send4(i == 0, 8'(16 * (i / 4) + (i % 4)));
    a_nready = 1'b0;
    total++;
    if (a_nvalid !== 1'b1) begin
      bad++; $display("FAIL rstmid_pre_valid: got %b want 1", a_nvalid);
    end
    #3 nReset = 1'b0;
    #1;
    total++;
    if (a_nvalid !== 1'b0 || a_word !== 32'h0) begin
      bad++; $display("FAIL rstmid_async: got v=%b %h want v=0 0", a_nvalid, a_word);
    end
    #10 nReset = 1'b1;
    @(posedge clock); #1;
    a_nready = 1'b1;
    run_frame4(1'b0, "after_rst");
  endtask

  task automatic test_random();
    logic [7:0] fr [3][640];
    logic [7:0] l, r, u;
    for (int f = 0; f < 3; f++) begin
      for (int y = 0; y < 3; y++)
        for (int x = 0; x < 640; x++) fr[y][x] = 8'($urandom);
      b_exp.delete(); b_q.delete();
      for (int y = 1; y < 3; y++)
        for (int x = 0; x < 640; x++) begin
          l = fr[y-1][(x == 0) ? 0 : x - 1];
          r = fr[y-1][(x == 639) ? 639 : x + 1];
          u = (y >= 2) ? fr[y-2][x] : fr[y-1][x];
          b_exp.push_back({9'(y - 1), 10'(x), fr[y][x], u, r, l});
        end
      drv_done = 1'b0;
      fork
        begin
          int w;
          for (int y = 0; y < 3; y++)
            for (int x = 0; x < 640; x++) begin
              if ($urandom_range(0, 3) == 0) begin
                @(posedge clock); #1;
              end
              b_valid = 1'b1; b_fs = (y == 0 && x == 0); b_data = fr[y][x]; w = 0;
              @(negedge clock);
              while (!b_ready && w < 1000) begin
                @(negedge clock);
                w++;
              end
              if (!b_ready) begin
                total++; bad++;
                $display("FAIL rand_timeout: pixelReady=%b required 1", b_ready);
              end
              @(posedge clock); #1;
              b_valid = 1'b0; b_fs = 1'b0;
            end
          drv_done = 1'b1;
        end
        begin
          while (!drv_done) begin
            @(posedge clock); #1;
            b_nready = 1'($urandom_range(0, 1));
          end
          b_nready = 1'b1;
        end
      join
      repeat (4) @(posedge clock);
      #1;
      total++;
      if (b_q.size() !== 1280) begin
        bad++; $display("FAIL rand_count frame=%0d: got %0d want 1280", f, b_q.size());
      end
      for (int i = 0; i < b_q.size() && i < b_exp.size(); i++) begin
        total++;
        if (b_q[i] !== b_exp[i]) begin
          bad++; $display("FAIL rand_word frame=%0d i=%0d: got %h want %h", f, i, b_q[i], b_exp[i]);
        end
      end
    end
  endtask

  initial begin
    exp4[0] = 32'h10_00_01_00; exp4[1] = 32'h11_01_02_00;
    exp4[2] = 32'h12_02_03_01; exp4[3] = 32'h13_03_03_02;
    exp4[4] = 32'h20_00_11_10; exp4[5] = 32'h21_01_12_10;
    exp4[6] = 32'h22_02_13_11; exp4[7] = 32'h23_03_13_12;
    test_reset();
    test_stream();
    test_backpressure();
    test_midframe();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
